// File: rtl/t05_huffman_decode_if.sv
// Bit-stream, SRAM node-read and character-out signals of the team 05 Huffman decoder.
// master = decoder side, slave = bit source / SRAM / byte sink side.
interface t05_huffman_decode_if #(
    parameter int IDX_W = 7
);
    logic             bit_in;
    logic             bit_valid;
    logic             last_bit;
    logic             bit_ready;
    logic [IDX_W-1:0] sram_addr;
    logic             sram_rd;
    logic [70:0]      sram_rdata;
    logic             sram_done;
    logic [7:0]       char_out;
    logic             char_valid;
    logic             char_ready;

    modport master (
        input  bit_in, bit_valid, last_bit, sram_rdata, sram_done, char_ready,
        output bit_ready, sram_addr, sram_rd, char_out, char_valid
    );

    modport slave (
        output bit_in, bit_valid, last_bit, sram_rdata, sram_done, char_ready,
        input  bit_ready, sram_addr, sram_rd, char_out, char_valid
    );
endinterface

// File: rtl/t05_huffman_decode.sv
// Huffman tree walker: fetches one SRAM node per step, consumes one bit per node, emits a byte per leaf.
// Optional T05_ROOT_CACHE_EN: keep the root's children so later symbols start without a root read.
module t05_huffman_decode #(
    parameter int IDX_W     = 7,
    parameter int MAX_DEPTH = 127
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [IDX_W-1:0]     root_idx,
    t05_huffman_decode_if.master bus,
    output logic                 dec_fin,
    output logic                 err,
    output logic [2:0]           state
);
    localparam int DW = $clog2(MAX_DEPTH + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_BIT   = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0] root_q, root_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [8:0]       left_q, left_d;
    logic [8:0]       right_q, right_d;
    logic [7:0]       char_q, char_d;
    logic             last_q, last_d;
    logic             dec_fin_q, dec_fin_d;
    logic             err_q, err_d;
    logic [8:0]       child;
`ifdef T05_ROOT_CACHE_EN
    logic [8:0]       root_left_q, root_left_d;
    logic [8:0]       root_right_q, root_right_d;
    logic             root_vld_q, root_vld_d;
`endif

    // node index and sum fields of the node word carry no decode information
    logic unused_rdata;
    assign unused_rdata = ^{bus.sram_rdata[70:64], bus.sram_rdata[45:0]};

    assign child = bus.bit_in ? right_q : left_q;

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        root_d    = root_q;
        depth_d   = depth_q;
        left_d    = left_q;
        right_d   = right_q;
        char_d    = char_q;
        last_d    = last_q;
        dec_fin_d = dec_fin_q;
        err_d     = err_q;
`ifdef T05_ROOT_CACHE_EN
        root_left_d  = root_left_q;
        root_right_d = root_right_q;
        root_vld_d   = root_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    cur_idx_d = root_idx;
                    root_d    = root_idx;
                    depth_d   = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                depth_d = (depth_q == '1) ? depth_q : depth_q + DW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (depth_q > DW'(MAX_DEPTH)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (bus.sram_done) begin
                    left_d  = bus.sram_rdata[63:55];
                    right_d = bus.sram_rdata[54:46];
`ifdef T05_ROOT_CACHE_EN
                    // first completed read after start is always the root
                    if (!root_vld_q) begin
                        root_left_d  = bus.sram_rdata[63:55];
                        root_right_d = bus.sram_rdata[54:46];
                        root_vld_d   = 1'b1;
                    end
`endif
                    state_d = S_BIT;
                end
            end
            S_BIT: begin
                if (bus.bit_valid) begin
                    if (!child[8]) begin
                        char_d  = child[7:0];
                        last_d  = bus.last_bit;
                        state_d = S_EMIT;
                    end else if (!child[7]) begin
                        cur_idx_d = IDX_W'(child[6:0]);
                        if (bus.last_bit) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_EMIT: begin
                if (bus.char_ready) begin
                    if (last_q) begin
                        dec_fin_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        depth_d   = '0;
                        cur_idx_d = root_q;
`ifdef T05_ROOT_CACHE_EN
                        left_d    = root_left_q;
                        right_d   = root_right_q;
                        state_d   = S_BIT;
`else
                        state_d   = S_FETCH;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        if (!en) begin
            state_d   = S_IDLE;
            cur_idx_d = '0;
            root_d    = '0;
            depth_d   = '0;
            left_d    = '0;
            right_d   = '0;
            char_d    = '0;
            last_d    = 1'b0;
            dec_fin_d = 1'b0;
            err_d     = 1'b0;
`ifdef T05_ROOT_CACHE_EN
            root_left_d  = '0;
            root_right_d = '0;
            root_vld_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_idx_q <= '0;
            root_q    <= '0;
            depth_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            char_q    <= '0;
            last_q    <= 1'b0;
            dec_fin_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef T05_ROOT_CACHE_EN
            root_left_q  <= '0;
            root_right_q <= '0;
            root_vld_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            root_q    <= root_d;
            depth_q   <= depth_d;
            left_q    <= left_d;
            right_q   <= right_d;
            char_q    <= char_d;
            last_q    <= last_d;
            dec_fin_q <= dec_fin_d;
            err_q     <= err_d;
`ifdef T05_ROOT_CACHE_EN
            root_left_q  <= root_left_d;
            root_right_q <= root_right_d;
            root_vld_q   <= root_vld_d;
`endif
        end
    end

    assign bus.bit_ready  = (state_q == S_BIT);
    assign bus.sram_rd    = (state_q == S_FETCH);
    assign bus.char_valid = (state_q == S_EMIT);
    assign bus.sram_addr  = cur_idx_q;
    assign bus.char_out   = char_q;
    assign dec_fin        = dec_fin_q;
    assign err            = err_q;
    assign state          = state_q;
endmodule

// File: tb/tb_t05_huffman_decode.sv
// Self-checking bench for t05_huffman_decode: SRAM responder, directed scenarios and random trees
// decoded against a tree-walk reference model.
module tb_t05_huffman_decode;
    localparam int IDX_W     = 7;
    localparam int MAX_DEPTH = 127;
`ifdef T05_ROOT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [IDX_W-1:0] root_idx;
    logic             dec_fin;
    logic             err;
    logic [2:0]       state;

    t05_huffman_decode_if #(.IDX_W(IDX_W)) bus();

    t05_huffman_decode #(.IDX_W(IDX_W), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .root_idx (root_idx),
        .bus      (bus),
        .dec_fin  (dec_fin),
        .err      (err),
        .state    (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [70:0] mem [0:127];
    int read_count = 0;
    int lat_fixed  = 0;
    int cv_cycles  = 0;
    logic       stream_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [8:0] lc [0:127];
    logic [8:0] rc [0:127];

    // SRAM model: one outstanding read, done pulse 1..3 cycles after sram_rd
    initial begin
        bus.sram_done  = 1'b0;
        bus.sram_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.sram_rd === 1'b1) begin
                int lat;
                logic [6:0] a;
                a = bus.sram_addr;
                read_count++;
                lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
                repeat (lat) @(posedge clk);
                #1;
                bus.sram_rdata = mem[a];
                bus.sram_done  = 1'b1;
                @(posedge clk); #1;
                bus.sram_done  = 1'b0;
                bus.sram_rdata = 71'(~mem[a]);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [70:0] mk(input logic [6:0] i, input logic [8:0] l, input logic [8:0] r);
        logic [63:0] junk;
        junk = {$urandom(), $urandom()};
        return {i, l, r, junk[45:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = '0;
    endtask

    task automatic setup_basic();
        clear_mem();
        mem[2] = mk(7'd2, 9'h041, 9'h101);
        mem[1] = mk(7'd1, 9'h042, 9'h043);
        root_idx = 7'd2;
    endtask

    task automatic stop_en();
        en = 1'b0;
        bus.bit_valid = 1'b0;
        bus.last_bit = 1'b0;
        bus.char_ready = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wait_bit_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.bit_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Drives stream_q with random valid/ready gaps until dec_fin or err (bounded)
    task automatic run_stream(input int vpct, input int rpct, output int used, output bit to);
        int n;
        used = 0;
        to = 1'b1;
        n = stream_q.size();
        got_q.delete();
        cv_cycles = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.bit_valid  = (used < n) && (int'($urandom_range(0, 99)) < vpct);
            bus.bit_in     = (used < n) ? stream_q[used] : 1'b0;
            bus.last_bit   = (used == n - 1);
            bus.char_ready = (int'($urandom_range(0, 99)) < rpct);
            if (bus.char_valid) cv_cycles++;
            if (bus.bit_ready && bus.bit_valid) used++;
            if (bus.char_valid && bus.char_ready) got_q.push_back(bus.char_out);
            if (dec_fin || err) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        bus.bit_valid = 1'b0;
        bus.last_bit = 1'b0;
        bus.char_ready = 1'b0;
    endtask

    task automatic build_tree(output logic [6:0] root);
        bit used_n [0:127];
        int ilist[$];
        int nsplit;
        clear_mem();
        for (int i = 0; i < 128; i++) used_n[i] = 1'b0;
        root = 7'($urandom_range(0, 127));
        used_n[root] = 1'b1;
        lc[root] = {1'b0, 8'($urandom)};
        rc[root] = {1'b0, 8'($urandom)};
        ilist.push_back(int'(root));
        nsplit = $urandom_range(0, 6);
        repeat (nsplit) begin
            int k;
            int j;
            bit side;
            k = ilist[$urandom_range(0, ilist.size() - 1)];
            side = 1'($urandom);
            if ((side ? rc[k][8] : lc[k][8]) == 1'b0) begin
                do j = $urandom_range(0, 127); while (used_n[j]);
                used_n[j] = 1'b1;
                lc[j] = {1'b0, 8'($urandom)};
                rc[j] = {1'b0, 8'($urandom)};
                if (side) rc[k] = {2'b10, 7'(j)};
                else      lc[k] = {2'b10, 7'(j)};
                ilist.push_back(j);
            end
        end
        foreach (ilist[i]) mem[ilist[i]] = mk(7'(ilist[i]), lc[ilist[i]], rc[ilist[i]]);
    endtask

    // Reference: random walk from the root per symbol; reads = nodes visited (root cached after first)
    task automatic gen_stream(input logic [6:0] root, input int nsym, output int exp_reads);
        int total_len;
        total_len = 0;
        stream_q.delete();
        exp_q.delete();
        for (int s = 0; s < nsym; s++) begin
            int node;
            node = int'(root);
            while (1) begin
                logic b;
                logic [8:0] ch;
                total_len++;
                b = 1'($urandom);
                ch = b ? rc[node] : lc[node];
                stream_q.push_back(b);
                if (ch[8] == 1'b0) begin
                    exp_q.push_back(ch[7:0]);
                    break;
                end
                node = int'(ch[6:0]);
            end
        end
        exp_reads = CACHE ? (total_len - nsym + 1) : total_len;
    endtask

    task automatic test_reset();
        total++;
        if ({state, bus.sram_addr, bus.sram_rd, bus.bit_ready, bus.char_out, bus.char_valid, dec_fin, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {state, bus.sram_addr, bus.sram_rd, bus.bit_ready,
                     bus.char_out, bus.char_valid, dec_fin, err});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        total++;
        if (state !== 3'd0 || bus.sram_rd !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_en_low state=%0d rd=%b exp state=0 rd=0", state, bus.sram_rd);
        end
    endtask

    task automatic test_basic();
        int used;
        bit to;
        logic [7:0] expc [3];
        expc[0] = 8'h41; expc[1] = 8'h42; expc[2] = 8'h43;
        setup_basic();
        stream_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        read_count = 0;
        en = 1'b1;
        run_stream(70, 70, used, to);
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout got=timeout exp=dec_fin"); end
        total++;
        if (got_q.size() != 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== expc[i]) begin bad++; $display("FAIL basic_char%0d got=%h exp=%h", i, got_q[i], expc[i]); end
        end
        total++;
        if (read_count != (CACHE ? 3 : 5)) begin
            bad++; $display("FAIL basic_reads got=%0d exp=%0d", read_count, CACHE ? 3 : 5);
        end
        repeat (3) tick();
        total++;
        if ({dec_fin, err, state} !== {1'b1, 1'b0, 3'd5}) begin
            bad++; $display("FAIL basic_done got fin=%b err=%b st=%0d exp fin=1 err=0 st=5", dec_fin, err, state);
        end
        en = 1'b0;
        tick();
        total++;
        if ({dec_fin, state} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL basic_clear got fin=%b st=%0d exp fin=0 st=0", dec_fin, state);
        end
        stop_en();
    endtask

    task automatic test_latency();
        bit ok;
        setup_basic();
        en = 1'b1;
        wait_bit_ready(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL lat_wait1 got=timeout exp=bit_ready"); end
        bus.bit_valid = 1'b1; bus.bit_in = 1'b0; bus.last_bit = 1'b0;
        tick();
        bus.bit_valid = 1'b0;
        total++;
        if ({bus.char_valid, bus.char_out} !== {1'b1, 8'h41}) begin
            bad++; $display("FAIL lat_leaf got cv=%b ch=%h exp cv=1 ch=41", bus.char_valid, bus.char_out);
        end
        bus.char_ready = 1'b1;
        tick();
        bus.char_ready = 1'b0;
        total++;
        if (bus.char_valid !== 1'b0) begin bad++; $display("FAIL lat_after_hs got cv=%b exp cv=0", bus.char_valid); end
        wait_bit_ready(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL lat_wait2 got=timeout exp=bit_ready"); end
        bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        total++;
        if ({bus.sram_rd, bus.sram_addr} !== {1'b1, 7'd1}) begin
            bad++; $display("FAIL lat_internal got rd=%b addr=%0d exp rd=1 addr=1", bus.sram_rd, bus.sram_addr);
        end
        wait_bit_ready(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL lat_wait3 got=timeout exp=bit_ready"); end
        bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.last_bit = 1'b1;
        tick();
        bus.bit_valid = 1'b0; bus.last_bit = 1'b0;
        total++;
        if ({bus.char_valid, bus.char_out} !== {1'b1, 8'h43}) begin
            bad++; $display("FAIL lat_leaf_last got cv=%b ch=%h exp cv=1 ch=43", bus.char_valid, bus.char_out);
        end
        bus.char_ready = 1'b1;
        tick();
        bus.char_ready = 1'b0;
        total++;
        if ({dec_fin, state} !== {1'b1, 3'd5}) begin
            bad++; $display("FAIL lat_done got fin=%b st=%0d exp fin=1 st=5", dec_fin, state);
        end
        stop_en();
    endtask

    task automatic test_null();
        int used;
        bit to;
        clear_mem();
        mem[4] = mk(7'd4, 9'h05A, 9'h180);
        root_idx = 7'd4;
        stream_q = '{1'b1};
        read_count = 0;
        en = 1'b1;
        run_stream(100, 100, used, to);
        repeat (3) tick();
        total++;
        if ({to, err, dec_fin, state} !== {1'b0, 1'b1, 1'b0, 3'd6}) begin
            bad++; $display("FAIL null_err got to=%b err=%b fin=%b st=%0d exp to=0 err=1 fin=0 st=6", to, err, dec_fin, state);
        end
        total++;
        if (cv_cycles != 0) begin bad++; $display("FAIL null_no_char got=%0d exp=0", cv_cycles); end
        en = 1'b0;
        tick();
        total++;
        if ({err, state} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL null_clear got err=%b st=%0d exp err=0 st=0", err, state);
        end
        stop_en();
        mem[4] = mk(7'd4, 9'h1C5, 9'h05A);
        stream_q = '{1'b0};
        en = 1'b1;
        run_stream(100, 100, used, to);
        total++;
        if ({to, err, state} !== {1'b0, 1'b1, 3'd6}) begin
            bad++; $display("FAIL illegal_err got to=%b err=%b st=%0d exp to=0 err=1 st=6", to, err, state);
        end
        stop_en();
    endtask

    task automatic test_truncated();
        int used;
        bit to;
        setup_basic();
        stream_q = '{1'b1};
        read_count = 0;
        en = 1'b1;
        run_stream(100, 100, used, to);
        repeat (6) tick();
        total++;
        if ({to, err, state} !== {1'b0, 1'b1, 3'd6}) begin
            bad++; $display("FAIL trunc_err got to=%b err=%b st=%0d exp to=0 err=1 st=6", to, err, state);
        end
        total++;
        if (read_count != 1) begin bad++; $display("FAIL trunc_reads got=%0d exp=1", read_count); end
        stop_en();
    endtask

    task automatic test_backpressure();
        bit ok;
        int hs;
        setup_basic();
        en = 1'b1;
        wait_bit_ready(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_wait got=timeout exp=bit_ready"); end
        bus.char_ready = 1'b0;
        bus.bit_valid = 1'b1; bus.bit_in = 1'b0; bus.last_bit = 1'b0;
        tick();
        bus.bit_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({bus.char_valid, bus.char_out, bus.bit_ready} !== {1'b1, 8'h41, 1'b0}) begin
                bad++; $display("FAIL bp_hold%0d got cv=%b ch=%h br=%b exp cv=1 ch=41 br=0",
                                c, bus.char_valid, bus.char_out, bus.bit_ready);
            end
            tick();
        end
        bus.char_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.char_valid && bus.char_ready) hs++;
            tick();
        end
        total++;
        if (hs != 1) begin bad++; $display("FAIL bp_single_hs got=%0d exp=1", hs); end
        stop_en();
    endtask

    task automatic test_abort();
        int used;
        bit to;
        setup_basic();
        lat_fixed = 3;
        en = 1'b1;
        tick();
        total++;
        if ({state, bus.sram_rd, bus.sram_addr} !== {3'd1, 1'b1, 7'd2}) begin
            bad++; $display("FAIL start_fetch got st=%0d rd=%b addr=%0d exp st=1 rd=1 addr=2", state, bus.sram_rd, bus.sram_addr);
        end
        tick();
        total++;
        if (state !== 3'd2) begin bad++; $display("FAIL abort_in_wait got=%0d exp=2", state); end
        en = 1'b0;
        tick();
        total++;
        if ({state, bus.sram_addr, bus.sram_rd, bus.bit_ready, bus.char_out, bus.char_valid, dec_fin, err} !== '0) begin
            bad++; $display("FAIL abort_outputs got=%h exp=0", {state, bus.sram_addr, bus.sram_rd, bus.bit_ready,
                            bus.char_out, bus.char_valid, dec_fin, err});
        end
        tick();
        tick();
        total++;
        if ({state, bus.bit_ready} !== {3'd0, 1'b0}) begin
            bad++; $display("FAIL abort_late_done got st=%0d br=%b exp st=0 br=0", state, bus.bit_ready);
        end
        read_count = 0;
        en = 1'b1;
        tick();
        total++;
        if ({bus.sram_rd, bus.sram_addr} !== {1'b1, 7'd2}) begin
            bad++; $display("FAIL abort_restart got rd=%b addr=%0d exp rd=1 addr=2", bus.sram_rd, bus.sram_addr);
        end
        stream_q = '{1'b0};
        run_stream(100, 100, used, to);
        total++;
        if (to || got_q.size() != 1 || dec_fin !== 1'b1) begin
            bad++; $display("FAIL abort_decode got to=%b n=%0d fin=%b exp to=0 n=1 fin=1", to, got_q.size(), dec_fin);
        end else begin
            total++;
            if (got_q[0] !== 8'h41) begin bad++; $display("FAIL abort_char got=%h exp=41", got_q[0]); end
        end
        total++;
        if (read_count != 1) begin bad++; $display("FAIL abort_reads got=%0d exp=1", read_count); end
        stop_en();
        lat_fixed = 0;
    endtask

    task automatic test_depth();
        int used;
        bit to;
        clear_mem();
        mem[3] = mk(7'd3, 9'h041, 9'h103);
        root_idx = 7'd3;
        stream_q.delete();
        repeat (MAX_DEPTH + 1) stream_q.push_back(1'b1);
        read_count = 0;
        en = 1'b1;
        run_stream(100, 100, used, to);
        repeat (6) tick();
        total++;
        if ({to, err, state} !== {1'b0, 1'b1, 3'd6}) begin
            bad++; $display("FAIL depth_err got to=%b err=%b st=%0d exp to=0 err=1 st=6", to, err, state);
        end
        total++;
        if (read_count != MAX_DEPTH + 1) begin
            bad++; $display("FAIL depth_reads got=%0d exp=%0d", read_count, MAX_DEPTH + 1);
        end
        total++;
        if (used != MAX_DEPTH) begin bad++; $display("FAIL depth_bits got=%0d exp=%0d", used, MAX_DEPTH); end
        stop_en();
    endtask

    task automatic random_round(input string tag, input int vpct, input int rpct);
        logic [6:0] r;
        int exp_reads;
        int used;
        bit to;
        build_tree(r);
        gen_stream(r, $urandom_range(1, 6), exp_reads);
        root_idx = r;
        read_count = 0;
        en = 1'b1;
        run_stream(vpct, rpct, used, to);
        total++;
        if (to || dec_fin !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL %s_finish got to=%b fin=%b err=%b exp to=0 fin=1 err=0", tag, to, dec_fin, err);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL %s_char%0d got=%h exp=%h", tag, i, got_q[i], exp_q[i]); end
        end
        total++;
        if (read_count != exp_reads) begin bad++; $display("FAIL %s_reads got=%0d exp=%0d", tag, read_count, exp_reads); end
        total++;
        if (used != stream_q.size()) begin bad++; $display("FAIL %s_bits got=%0d exp=%0d", tag, used, stream_q.size()); end
        stop_en();
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++)
            random_round("rand", int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) random_round("b2b", 100, 100);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        root_idx = '0;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.last_bit = 1'b0;
        bus.char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_latency();
        test_null();
        test_truncated();
        test_backpressure();
        test_abort();
        test_depth();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
